bcd_counter_n: RTL and testbench

//  Parametrised N-digit BCD counter; next generation of the 4-digit 0000-9999 counter.
//  - Adds up/down counting, count enable, synchronous load, a run-time upper limit
//    (count range 0..limite) and a wrap or saturate mode.
//  - Used by the alarm-clock datapath for seconds/minutes/hours fields and set-mode

---
 rtl/bcd_counter_n_pkg.sv | 9 +
 rtl/bcd_counter_n_bcd_digit.sv | 22 ++
 rtl/bcd_counter_n.sv | 93 +++++++++
 tb/tb_bcd_counter_n.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/bcd_counter_n_pkg.sv
// bcd_counter_n_pkg: shared BCD constants and bound-mode encoding for the N-digit BCD counter
package bcd_counter_n_pkg;
    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;
    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } mode_e;
endpackage

// File: rtl/bcd_counter_n_bcd_digit.sv
// bcd_digit: one BCD digit slice of the ripple increment/decrement chain
//   cin_i   in  1  step request from the lower digit (1 into digit 0)
//   up_i    in  1  1: increment, 0: decrement
//   value_i in  4  current digit value (valid BCD)
//   next_o  out 4  stepped digit value
//   cout_o  out 1  carry (up) or borrow (down) into the next digit
module bcd_digit
    import bcd_counter_n_pkg::*;
(
    input  logic       cin_i,
    input  logic       up_i,
    input  logic [3:0] value_i,
    output logic [3:0] next_o,
    output logic       cout_o
);
    logic at_edge;
    assign at_edge = up_i ? (value_i == BCD_MAX) : (value_i == BCD_ZERO);
    assign cout_o  = cin_i & at_edge;
    assign next_o  = !cin_i ? value_i :
                     at_edge ? (up_i ? BCD_ZERO : BCD_MAX) :
                     up_i ? value_i + 4'd1 : value_i - 4'd1;
endmodule

// File: rtl/bcd_counter_n.sv
// bcd_counter_n: N-digit up/down BCD counter with load, run-time upper limit and wrap/saturate
//   reloj      in  1          count clock, rising edge
//   reseteador in  1          asynchronous active-high reset
//   en         in  1          count enable
//   up         in  1          1: increment, 0: decrement
//   load       in  1          synchronous load of load_val (beats en)
//   load_val   in  4*DIGITS   packed BCD load value
//   limite     in  4*DIGITS   packed BCD inclusive upper bound
//   cuenta     out 4*DIGITS   registered count
//   carry      out 1          one-cycle bound event
//   err        out 1          one-cycle rejected-load pulse
module bcd_counter_n
    import bcd_counter_n_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter bit SATURATE = 1'b0
) (
    input  logic                  reloj,
    input  logic                  reseteador,
    input  logic                  en,
    input  logic                  up,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic [4*DIGITS-1:0]   limite,
    output logic [4*DIGITS-1:0]   cuenta,
    output logic                  carry,
    output logic                  err
);
    localparam int    W    = 4*DIGITS;
    localparam mode_e MODE = SATURATE ? MODE_SAT : MODE_WRAP;

    logic [W-1:0]   cuenta_q, cuenta_d, lim, stepped;
    logic           carry_q, carry_d, err_q, err_d, lim_ok, lv_ok;
    logic [DIGITS:0] c;

    always_comb begin
        lim_ok = 1'b1;
        lv_ok  = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            lim_ok = lim_ok & (limite[4*k +: 4] <= BCD_MAX);
            lv_ok  = lv_ok & (load_val[4*k +: 4] <= BCD_MAX);
        end
    end

    // A malformed limit falls back to the full range rather than a garbage bound.
    assign lim  = lim_ok ? limite : {DIGITS{BCD_MAX}};
    assign c[0] = 1'b1;

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        bcd_digit u_dig (
            .cin_i   (c[g]),
            .up_i    (up),
            .value_i (cuenta_q[4*g +: 4]),
            .next_o  (stepped[4*g +: 4]),
            .cout_o  (c[g+1])
        );
    end

    // In down mode the borrow leaves the top digit only when every digit is zero,
    // so c[DIGITS] doubles as the zero detect.
    always_comb begin
        cuenta_d = cuenta_q;
        carry_d  = 1'b0;
        err_d    = 1'b0;
        if (load) begin
            err_d    = !lv_ok;
            cuenta_d = !lv_ok ? cuenta_q : (load_val > lim) ? lim : load_val;
        end else if (en && up) begin
            carry_d  = cuenta_q >= lim;
            cuenta_d = !carry_d ? stepped : (MODE == MODE_SAT) ? cuenta_q : '0;
        end else if (en) begin
            carry_d  = c[DIGITS];
            cuenta_d = carry_d ? ((MODE == MODE_SAT) ? cuenta_q : lim) :
                       (cuenta_q > lim) ? lim : stepped;
        end
    end

    always_ff @(posedge reloj or posedge reseteador) begin
        if (reseteador) begin
            cuenta_q <= '0;
            carry_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            cuenta_q <= cuenta_d;
            carry_q  <= carry_d;
            err_q    <= err_d;
        end
    end

    assign cuenta = cuenta_q;
    assign carry  = carry_q;
    assign err    = err_q;
endmodule

// File: tb/tb_bcd_counter_n.sv
// tb_bcd_counter_n: directed table and sequence checks of wrap and saturate 4-digit counters
module tb_bcd_counter_n;
    logic        reloj = 1'b0, reseteador = 1'b1, en = 1'b0, up = 1'b1, load = 1'b0;
    logic [15:0] load_val = '0, limite = 16'h9999;
    logic [15:0] cw, cs;
    logic        kw, ks, ew, es;
    int          tests = 0, fails = 0;

    always #5 reloj = ~reloj;

    bcd_counter_n #(.DIGITS(4), .SATURATE(1'b0)) dut_w (
        .reloj(reloj), .reseteador(reseteador), .en(en), .up(up), .load(load),
        .load_val(load_val), .limite(limite), .cuenta(cw), .carry(kw), .err(ew));
    bcd_counter_n #(.DIGITS(4), .SATURATE(1'b1)) dut_s (
        .reloj(reloj), .reseteador(reseteador), .en(en), .up(up), .load(load),
        .load_val(load_val), .limite(limite), .cuenta(cs), .carry(ks), .err(es));

    typedef struct {
        logic        ld;
        logic [15:0] lv;
        logic        en;
        logic        up;
        logic [15:0] lim;
        logic [15:0] xcw;
        logic        xkw;
        logic [15:0] xcs;
        logic        xks;
        logic        xer;
    } vec_t;

    vec_t v [32];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge reloj);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ncarry, at;
        v[0]  = '{1, 16'h0008, 0, 1, 16'h9999, 16'h0008, 0, 16'h0008, 0, 0};
        v[1]  = '{0, 16'h0000, 1, 1, 16'h9999, 16'h0009, 0, 16'h0009, 0, 0};
        v[2]  = '{0, 16'h0000, 1, 1, 16'h9999, 16'h0010, 0, 16'h0010, 0, 0};
        v[3]  = '{1, 16'h0999, 0, 1, 16'h9999, 16'h0999, 0, 16'h0999, 0, 0};
        v[4]  = '{0, 16'h0000, 1, 1, 16'h9999, 16'h1000, 0, 16'h1000, 0, 0};
        v[5]  = '{1, 16'h9998, 0, 1, 16'h9999, 16'h9998, 0, 16'h9998, 0, 0};
        v[6]  = '{0, 16'h0000, 1, 1, 16'h9999, 16'h9999, 0, 16'h9999, 0, 0};
        v[7]  = '{0, 16'h0000, 1, 1, 16'h9999, 16'h0000, 1, 16'h9999, 1, 0};
        v[8]  = '{0, 16'h0000, 1, 1, 16'h9999, 16'h0001, 0, 16'h9999, 1, 0};
        v[9]  = '{1, 16'h0A12, 0, 1, 16'h9999, 16'h0001, 0, 16'h9999, 0, 1};
        v[10] = '{1, 16'h0075, 0, 1, 16'h0059, 16'h0059, 0, 16'h0059, 0, 0};
        v[11] = '{1, 16'h0058, 1, 1, 16'h0059, 16'h0058, 0, 16'h0058, 0, 0};
        v[12] = '{0, 16'h0000, 1, 1, 16'h0059, 16'h0059, 0, 16'h0059, 0, 0};
        v[13] = '{0, 16'h0000, 1, 1, 16'h0059, 16'h0000, 1, 16'h0059, 1, 0};
        v[14] = '{0, 16'h0000, 1, 0, 16'h0059, 16'h0059, 1, 16'h0058, 0, 0};
        v[15] = '{0, 16'h0000, 0, 0, 16'h0059, 16'h0059, 0, 16'h0058, 0, 0};
        v[16] = '{1, 16'h0000, 0, 0, 16'h0059, 16'h0000, 0, 16'h0000, 0, 0};
        v[17] = '{0, 16'h0000, 1, 0, 16'h0059, 16'h0059, 1, 16'h0000, 1, 0};
        v[18] = '{1, 16'h0023, 0, 1, 16'h0023, 16'h0023, 0, 16'h0023, 0, 0};
        v[19] = '{0, 16'h0000, 1, 1, 16'h0023, 16'h0000, 1, 16'h0023, 1, 0};
        v[20] = '{0, 16'h0000, 1, 1, 16'h0023, 16'h0001, 0, 16'h0023, 1, 0};
        v[21] = '{1, 16'h0040, 0, 1, 16'h9999, 16'h0040, 0, 16'h0040, 0, 0};
        v[22] = '{0, 16'h0000, 1, 1, 16'h0030, 16'h0000, 1, 16'h0040, 1, 0};
        v[23] = '{1, 16'h0040, 0, 1, 16'h9999, 16'h0040, 0, 16'h0040, 0, 0};
        v[24] = '{0, 16'h0000, 1, 0, 16'h0030, 16'h0030, 0, 16'h0030, 0, 0};
        v[25] = '{1, 16'h9999, 0, 1, 16'h00F0, 16'h9999, 0, 16'h9999, 0, 0};
        v[26] = '{1, 16'h0005, 0, 1, 16'h0000, 16'h0000, 0, 16'h0000, 0, 0};
        v[27] = '{0, 16'h0000, 1, 1, 16'h0000, 16'h0000, 1, 16'h0000, 1, 0};
        v[28] = '{0, 16'h0000, 1, 0, 16'h0000, 16'h0000, 1, 16'h0000, 1, 0};
        v[29] = '{1, 16'hA000, 0, 1, 16'h9999, 16'h0000, 0, 16'h0000, 0, 1};
        v[30] = '{1, 16'h1000, 0, 1, 16'h9999, 16'h1000, 0, 16'h1000, 0, 0};
        v[31] = '{0, 16'h0000, 1, 0, 16'h9999, 16'h0999, 0, 16'h0999, 0, 0};

        #12;
        chk("reset cuenta_w", cw, 16'h0000);
        chk("reset cuenta_s", cs, 16'h0000);
        chk("reset flags_w", {14'd0, kw, ew}, 16'h0000);
        chk("reset flags_s", {14'd0, ks, es}, 16'h0000);
        @(negedge reloj);
        reseteador = 1'b0;
        step();

        for (int i = 0; i < 32; i++) begin
            load = v[i].ld; load_val = v[i].lv; en = v[i].en; up = v[i].up; limite = v[i].lim;
            step();
            chk($sformatf("vec%0d cuenta_w", i), cw, v[i].xcw);
            chk($sformatf("vec%0d carry_w", i), {15'd0, kw}, {15'd0, v[i].xkw});
            chk($sformatf("vec%0d err_w", i), {15'd0, ew}, {15'd0, v[i].xer});
            chk($sformatf("vec%0d cuenta_s", i), cs, v[i].xcs);
            chk($sformatf("vec%0d carry_s", i), {15'd0, ks}, {15'd0, v[i].xks});
            chk($sformatf("vec%0d err_s", i), {15'd0, es}, {15'd0, v[i].xer});
        end

        // seconds field: exactly one carry in 60 up steps, on the 0059 -> 0000 edge
        load = 1'b1; load_val = 16'h0000; en = 1'b0; up = 1'b1; limite = 16'h0059;
        step();
        load = 1'b0; en = 1'b1;
        ncarry = 0; at = -1;
        for (int i = 1; i <= 60; i++) begin
            step();
            if (kw) begin ncarry++; at = i; end
        end
        chk("sec carry count", 16'(ncarry), 16'd1);
        chk("sec carry step", 16'(at), 16'd60);
        chk("sec final cuenta", cw, 16'h0000);

        // asynchronous reset between edges in the middle of a count
        load = 1'b1; load_val = 16'h0457; en = 1'b0; limite = 16'h9999;
        step();
        chk("pre-reset cuenta", cw, 16'h0457);
        load = 1'b0; en = 1'b1; up = 1'b1;
        #2 reseteador = 1'b1;
        #1;
        chk("async reset cuenta_w", cw, 16'h0000);
        chk("async reset cuenta_s", cs, 16'h0000);
        chk("async reset flags", {12'd0, kw, ew, ks, es}, 16'h0000);
        reseteador = 1'b0;
        step();
        chk("resume cuenta", cw, 16'h0001);

        // enable low holds for ten edges
        en = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step();
            chk($sformatf("hold%0d cuenta", i), cw, 16'h0001);
            chk($sformatf("hold%0d carry", i), {15'd0, kw}, 16'h0000);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
